fpa_arbiter: RTL

Round-robin controller that shares one multi-cycle floating-point adder (the `fpa` datapath) among NREQ requesters. It does the following:
- accepts operand pairs over per-requester valid/ready handshakes;
- sequences the adder through start/done;
- latches the sum and returns it to the granted requester over a response handshake.

It sits between the requesting engines and the single adder instance.

---
 rtl/fpa_arbiter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/fpa_arbiter.sv
// Round-robin controller sharing one multi-cycle floating-point adder among NREQ requesters.
// Define FPA_ARB_WDOG_EN to build the adder watchdog (quiet-NaN error response after TIMEOUT WAIT cycles).
module fpa_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*32-1:0]   req_x,
  input  logic [NREQ*32-1:0]   req_y,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [31:0]          rsp_result,
  output logic                 rsp_err,
  output logic                 fpa_start,
  output logic [31:0]          fpa_x,
  output logic [31:0]          fpa_y,
  input  logic [31:0]          fpa_result,
  input  logic                 fpa_done
);

  localparam int          PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [PW-1:0] r_ptr;
  logic [PW-1:0] r_gnt;
  logic [PW-1:0] w_gnt;
  logic          w_any;
  logic          w_hs;
  logic          w_timeout;
  logic [31:0]   r_x;
  logic [31:0]   r_y;
  logic [31:0]   r_result;

  // First valid requester at or after r_ptr, wrapping modulo NREQ.
  always_comb begin
    int idx;
    idx   = 0;
    w_any = 1'b0;
    w_gnt = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(r_ptr) + k) % NREQ;
      if (!w_any && req_valid[idx]) begin
        w_any = 1'b1;
        w_gnt = PW'(idx);
      end
    end
  end

  assign w_hs = (r_state == S_RESP) && rsp_ready[r_gnt];

`ifdef FPA_ARB_WDOG_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_wdog;
  logic          r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wdog <= '0;
    end else if (r_state == S_ISSUE) begin
      r_wdog <= '0;
    end else if (r_state == S_WAIT) begin
      r_wdog <= r_wdog + 1'b1;
    end
  end

  // Last permitted WAIT cycle without done: the response is forced on this edge.
  assign w_timeout = (r_state == S_WAIT) && !fpa_done && (r_wdog == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (r_state == S_IDLE && w_any) begin
      r_err <= 1'b0;
    end else if (w_timeout) begin
      r_err <= 1'b1;
    end
  end

  assign rsp_err = r_err;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT > 0);
  assign w_timeout        = 1'b0;
  assign rsp_err          = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_next = S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (fpa_done || w_timeout) w_next = S_RESP;
      S_RESP:  if (w_hs) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // req_ready is combinational and must read zero while reset is held.
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    fpa_start = 1'b0;
    case (r_state)
      S_IDLE:  if (w_any && !rst) req_ready[w_gnt] = 1'b1;
      S_ISSUE: fpa_start = 1'b1;
      S_RESP:  rsp_valid[r_gnt] = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr    <= '0;
      r_gnt    <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_result <= '0;
    end else begin
      if (r_state == S_IDLE && w_any) begin
        r_gnt <= w_gnt;
        r_x   <= req_x[32*int'(w_gnt) +: 32];
        r_y   <= req_y[32*int'(w_gnt) +: 32];
      end
      if (r_state == S_WAIT && fpa_done) begin
        r_result <= fpa_result;
      end else if (w_timeout) begin
        r_result <= QNAN;
      end
      if (w_hs) begin
        r_ptr <= (int'(r_gnt) == NREQ - 1) ? '0 : r_gnt + 1'b1;
      end
    end
  end

  assign fpa_x      = r_x;
  assign fpa_y      = r_y;
  assign rsp_result = r_result;

endmodule
